seq_divider: RTL

- Bit-serial restoring unsigned divider. It is the inverse operation to the team's multiplier datapath.
- Each iteration performs one trial subtraction, which is a WIDTH+1-bit adder in subtract mode, and retires one quotient bit per clock.
- It sits beside the multiplier as a multi-cycle arithmetic unit with a start/busy/done handshake.
- The bench drives it the same way as the other arithmetic blocks.

---
 rtl/seq_divider.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: bit-serial restoring unsigned divider.
// One trial subtraction (WIDTH+1-bit) per clock, one quotient bit retired per clock.
// The handshake is start/busy/done. Results are held in q/r/div_by_zero until the next
// operation completes.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH:0]   p_reg, p_next;       // partial remainder
    logic [WIDTH-1:0] dq_reg, dq_next;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_reg, dvs_next;   // captured divisor
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] dq_step;
    logic             qbit;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor,
    // and keep the difference only when it did not go negative.
    always_comb begin
        shifted = {p_reg[WIDTH-1:0], dq_reg[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_reg};
        qbit    = ~trial[WIDTH];
        p_step  = qbit ? trial : shifted;
        dq_step = {dq_reg[WIDTH-2:0], qbit};
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            p_reg     <= '0;
            dq_reg    <= '0;
            dvs_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            dq_reg    <= dq_next;
            dvs_reg   <= dvs_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            dbz_reg   <= dbz_next;
        end
    end

    // Next-state logic. A start is accepted in IDLE and also in DONE, which gives back-to-back operation.
    // A zero divisor skips RUN entirely.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        dq_next    = dq_reg;
        dvs_next   = dvs_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        dbz_next   = dbz_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    dvs_next = b;
                    dq_next  = a;
                    p_next   = '0;
                    cnt_next = '0;
                    if (b == '0) begin
                        state_next = DONE;
                        q_next     = '1;
                        r_next     = a;
                        dbz_next   = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                cnt_next = cnt_reg + CW'(1);
                p_next   = p_step;
                dq_next  = dq_step;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                    q_next     = dq_step;
                    r_next     = p_step[WIDTH-1:0];
                    dbz_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign q           = q_reg;
    assign r           = r_reg;
    assign div_by_zero = dbz_reg;

endmodule
